// File: rtl/count_chk_pkg.sv
// Shared definitions for the count_checker block: FSM state encoding and
// the widths of the monitored count and of the statistics counters.
package count_chk_pkg;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 8;

    // Largest value of the monitored counter; a step from here to 0 is a wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Code 2'd3 is deliberately left unused and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/count_checker_sat_cnt8.sv
// Statistics counter with synchronous clear and increment enable.
// It holds at all-ones instead of rolling over.
module sat_cnt8
    import count_chk_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_reg;

    // Clear has priority; increments stop once the counter is full.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + STAT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/count_checker.sv
// Watches a free-running 4-bit counter and locks once SYNC_LEN consecutive
// good steps have been seen. In lock it counts wraps and mismatches.
// All outputs are registered, so every event shows up one cycle after the
// edge that sampled it.
module count_checker
    import count_chk_pkg::*;
#(
    parameter int SYNC_LEN   = 4,
    parameter int ALLOW_HOLD = 0
) (
    input  logic              clk,
    input  logic              rs,
    input  logic [CNT_W-1:0]  q_in,
    output logic              locked,
    output logic              wrap,
    output logic              err,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [STAT_W-1:0] err_cnt,
    output logic [1:0]        state
);

    // gcnt carries one extra bit so that "gcnt + 1" cannot overflow when it
    // is compared against SYNC_LEN = 15.
    localparam logic [CNT_W:0] SYNC_TARGET = (CNT_W+1)'(SYNC_LEN);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  q_prev_reg;
    logic [CNT_W-1:0]  gcnt_reg, gcnt_next;
    logic              locked_reg;
    logic              wrap_reg, wrap_next;
    logic              err_reg, err_next;
    logic [STAT_W-1:0] wrap_cnt_reg;

    logic [CNT_W-1:0]  expected;
    logic [CNT_W:0]    gcnt_inc;
    logic              good_step;
    logic              wrap_step;
    logic              sync_done;

    // Step classification against the previously sampled value.
    always_comb begin
        expected  = q_prev_reg + CNT_W'(1);
        good_step = (q_in == expected) ||
                    ((ALLOW_HOLD != 0) && (q_in == q_prev_reg));
        // A wrap is always a good step; a held 15 never qualifies.
        wrap_step = (q_prev_reg == CNT_MAX) && (q_in == '0);
        gcnt_inc  = {1'b0, gcnt_reg} + (CNT_W+1)'(1);
        sync_done = (gcnt_inc == SYNC_TARGET);
    end

    // Acquisition FSM: next state, good-step counter and event pulses.
    always_comb begin
        state_next = state_reg;
        gcnt_next  = gcnt_reg;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                gcnt_next  = '0;
                state_next = SYNC;
            end
            SYNC: begin
                if (good_step) begin
                    gcnt_next = gcnt_inc[CNT_W-1:0];
                    if (sync_done) begin
                        state_next = LOCK;
                        // The step that completes a resync already counts.
                        wrap_next  = wrap_step;
                    end
                end else begin
                    gcnt_next = '0;
                end
            end
            LOCK: begin
                if (good_step) begin
                    wrap_next = wrap_step;
                end else begin
                    err_next   = 1'b1;
                    gcnt_next  = '0;
                    state_next = SYNC;
                end
            end
            default: begin
                gcnt_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, sample history and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_reg    <= IDLE;
            q_prev_reg   <= '0;
            gcnt_reg     <= '0;
            locked_reg   <= 1'b0;
            wrap_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wrap_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            q_prev_reg   <= q_in;
            gcnt_reg     <= gcnt_next;
            locked_reg   <= (state_next == LOCK);
            wrap_reg     <= wrap_next;
            err_reg      <= err_next;
            wrap_cnt_reg <= wrap_cnt_reg + STAT_W'(wrap_next);
        end
    end

    // Mismatch statistics saturate rather than wrap.
    sat_cnt8 u_err_cnt (
        .clk   (clk),
        .clr   (rs),
        .inc   (err_next),
        .count (err_cnt)
    );

    assign locked   = locked_reg;
    assign wrap     = wrap_reg;
    assign err      = err_reg;
    assign wrap_cnt = wrap_cnt_reg;
    assign state    = state_reg;

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 4: consecutive correct steps needed to reach LOCK (legal range 1..15).
REQ-002 SHALL have parameter ALLOW_HOLD, default 0: 1 = a repeated value is legal; 0 = a repeated value is a mismatch.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rs  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port q_in  input  4  count value from the upstream 4-bit counter, sampled every clk edge.
REQ-006 SHALL have port locked  output  1  high while in state LOCK.
REQ-007 SHALL have port wrap  output  1  one-cycle pulse on a legal 15->0 step.
REQ-008 SHALL have port err  output  1  one-cycle pulse on a mismatch seen in LOCK.
REQ-009 SHALL have port wrap_cnt  output  8  legal wraps seen in LOCK, modulo 256.
REQ-010 SHALL have port err_cnt  output  8  mismatches seen in LOCK, saturating at 255.
REQ-011 SHALL have port state  output  2  current FSM state code.

Function
REQ-012 SHALL register q_in into q_prev on every non-reset edge.
REQ-013 SHALL define expected = (q_prev + 1) mod 16.
- 4-bit add; carry discarded.
- 15 -> 0 is a legal step.
REQ-014 SHALL classify a sample as a good step when:
- q_in == expected; or
- ALLOW_HOLD=1 and q_in == q_prev.
- Anything else is a mismatch.
REQ-015 SHALL implement FSM states IDLE=0, SYNC=1, LOCK=2; code 3 unused and recovers to IDLE on the next edge.
REQ-016 SHALL, in IDLE:
- capture q_in;
- clear good-step counter gcnt;
- move to SYNC on the next edge.
REQ-017 SHALL, in SYNC:
- increment gcnt on a good step;
- clear gcnt on a mismatch;
- enter LOCK on the edge where gcnt would reach SYNC_LEN;
- assert no err.
REQ-018 SHALL, in LOCK, stay in LOCK on a good step.
REQ-019 SHALL, on a mismatch in LOCK:
- pulse err;
- increment err_cnt (saturating);
- clear gcnt;
- go to SYNC.
REQ-020 SHALL pulse wrap and increment wrap_cnt only on a legal q_prev=15, q_in=0 step while in LOCK, including the step that completes a resync into LOCK.
REQ-021 SHALL, with ALLOW_HOLD=1, not count 15->15 as a wrap.
REQ-022 SHALL register all outputs: an event sampled at edge n is visible after edge n (one-cycle latency), and err/wrap are high for exactly one cycle.
REQ-023 SHALL, when a mismatch and a 15->0-looking value coincide, treat the sample as a mismatch only: err=1, wrap=0.
REQ-024 SHALL hold err_cnt at 255 under further mismatches, and roll wrap_cnt from 255 to 0.

Reset
REQ-025 SHALL, when rs=1 at an edge, on that edge:
- force state=IDLE;
- clear q_prev, gcnt, wrap_cnt and err_cnt;
- set locked=0, wrap=0, err=0.
REQ-026 SHALL give reset priority over every other event, including mid-LOCK and mid-resync.
REQ-027 SHALL, after reset release, restart acquisition from IDLE; no count values survive reset.

Structure
REQ-028 SHALL place in shared package count_chk_pkg:
- state encoding constants IDLE/SYNC/LOCK;
- count width 4;
- statistics width 8.
REQ-029 SHALL instantiate one sub-module sat_cnt8: 8-bit counter with synchronous clear and increment enable, used for err_cnt.
REQ-030 SHALL be 120-400 lines of RTL total, with no latches, no multicycle paths and no second clock.

Verification
REQ-031 SHALL cover clean acquisition:
- stimulus: rs high 1 cycle, then q_in=0,1,2,... each cycle;
- response: state goes IDLE->SYNC->LOCK; locked first high after the 5th edge following release (SYNC_LEN=4).
REQ-032 SHALL cover wrap:
- stimulus: locked stream 13,14,15,0,1;
- response: wrap pulses exactly once, one cycle after the 0 is sampled; wrap_cnt 0->1.
REQ-033 SHALL cover a glitch:
- stimulus: locked stream 5,6,9,10,11,12,13;
- response: err pulses once after 9; err_cnt=1; state=SYNC; locked returns after 10,11,12,13 are sampled.
REQ-034 SHALL cover saturation:
- stimulus: 300 alternating mismatch/resync episodes;
- response: err_cnt stops at 255; wrap_cnt wraps past 255 to 0 under a long locked run.
REQ-035 SHALL cover reset mid-operation:
- stimulus: rs=1 for one cycle while locked with wrap_cnt=3, err_cnt=2;
- response: next cycle state=IDLE, all counters 0, locked=0.
REQ-036 SHALL cover hold mode:
- stimulus: ALLOW_HOLD=1, stream 4,4,5,5,6,7,8;
- response: no err; LOCK reached.
- same stream with ALLOW_HOLD=0 never locks in time: gcnt keeps clearing.
